sub_tc_16_16_seq: RTL and testbench
===================================

Name: sub_tc_16_16_seq

Overview:
- Multi-cycle two's-complement subtractor: diff = a - b, sign-extended to WIDTH+1 bits.
- Complements the combinational 16-bit two's-complement adder in the arithmetic datapath, covering the subtract direction.
- Processes DIGIT bits per cycle, LSB digit first, through a valid/ready input and output handshake.
- Placed where area matters more than latency.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per clock cycle.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, two's complement.
- b  input  WIDTH  subtrahend, two's complement.
- out_valid  output  1  diff is valid.
- out_ready  input  1  downstream accepts diff.
- diff  output  WIDTH+1  a - b, two's complement, sign-extended.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset: on a clk edge with rst_n=0, state=IDLE, out_valid=0, diff=0, internal carry/count/shift registers cleared. in_ready=1 from the first cycle after reset.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE) and is decoded from registered state only.
- IDLE -> CALC on in_valid&&in_ready:
  - capture a into A, ~b into NB;
  - carry=1 (the +1 of two's-complement negation);
  - digit count cnt=0.
- CALC, each cycle:
  - {c, s} = A[DIGIT-1:0] + NB[DIGIT-1:0] + carry;
  - s is shifted into the result register from the MSB side;
  - A and NB shift right by DIGIT; carry=c; cnt++.
  - On the cycle where cnt==WIDTH/DIGIT-1: compute diff[WIDTH] = a[WIDTH-1] ^ ~b[WIDTH-1] ^ c, load diff, go to DONE.
- Latency: out_valid rises WIDTH/DIGIT cycles after the accepting edge (4 for defaults).
- DONE: out_valid=1; diff is held stable.
  - out_valid && out_ready -> IDLE; out_valid=0 on the next cycle.
  - No new operand is accepted in the same cycle as the output handshake.
- Back-pressure: out_ready=0 holds DONE indefinitely; diff and out_valid stay stable.
- in_valid while CALC or DONE is ignored (in_ready=0). Operand changes after acceptance have no effect.
- diff is registered and retains its last value after the output handshake until the next result loads.
- Reset mid-operation (CALC or DONE): the transaction is dropped silently, state returns to IDLE and out_valid=0 on that edge.
- Result range: full WIDTH+1 range. -2^WIDTH+1 .. 2^WIDTH-1 are all exact; no wrap.

Optional Feature:
- Macro SUB_TC_OVF_EN.
- Defined:
  - adds output port ovf (output, 1 bit);
  - ovf = diff[WIDTH] ^ diff[WIDTH-1], i.e. the result does not fit in WIDTH signed bits;
  - ovf is registered with diff, valid while out_valid=1, reset value 0.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, idle: in_ready=1, out_valid=0, diff=0x00000. Then a=0x6080, b=0x8001 accepted -> out_valid exactly 4 cycles later, diff=0x0E07F, ovf=1.
- a=0x8001, b=0x8001 -> diff=0x00000, ovf=0. a=0x0005, b=0x0007 -> diff=0x1FFFE, ovf=0.
- Extremes:
  - a=0x7FFF, b=0x8000 -> diff=0x0FFFF, ovf=1;
  - a=0x8000, b=0x7FFF -> diff=0x10001, ovf=1.
- Back-pressure: hold out_ready=0 for 6 cycles after out_valid -> diff stable, in_ready=0. Drive in_valid=1 with new operands meanwhile -> ignored. Release out_ready -> one handshake, IDLE, then the new operands are accepted.
- Reset mid-CALC: assert rst_n=0 for one edge 2 cycles after accept -> out_valid never asserts, in_ready=1 next cycle, next operation a=0x0003, b=0x0001 -> diff=0x00002.
- Back-to-back: in_valid and out_ready held high over 4 operand pairs -> each result correct, one accept per WIDTH/DIGIT+2 cycles, no dropped or duplicated results.

Source files
------------

// File: rtl/sub_tc_16_16_seq.sv
// Digit-serial two's-complement subtractor: diff = a - b (WIDTH+1 bits), DIGIT bits per cycle, LSB first.
// Optional overflow flag output is enabled by defining SUB_TC_OVF_EN.
module sub_tc_16_16_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff
`ifdef SUB_TC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   aSh_q;
  logic [WIDTH-1:0]   nbSh_q;
  logic               carry_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   res_q;
  logic               signA_q;
  logic               signNb_q;
  logic [WIDTH:0]     diff_q;
  logic               outValid_q;
`ifdef SUB_TC_OVF_EN
  logic               ovf_q;
`endif

  logic [DIGIT:0]       digit_d;
  logic [WIDTH+DIGIT-1:0] resCat_d;
  logic [WIDTH-1:0]     res_d;
  logic                 top_d;

  // One digit of A + ~B + carry; the new sum digit enters the result from the MSB side.
  always_comb begin
    digit_d  = {1'b0, aSh_q[DIGIT-1:0]} + {1'b0, nbSh_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    resCat_d = {digit_d[DIGIT-1:0], res_q};
    res_d    = resCat_d[WIDTH+DIGIT-1:DIGIT];
    top_d    = signA_q ^ signNb_q ^ digit_d[DIGIT];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      aSh_q      <= '0;
      nbSh_q     <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      res_q      <= '0;
      signA_q    <= 1'b0;
      signNb_q   <= 1'b0;
      diff_q     <= '0;
      outValid_q <= 1'b0;
`ifdef SUB_TC_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            aSh_q    <= a;
            nbSh_q   <= ~b;
            signA_q  <= a[WIDTH-1];
            signNb_q <= ~b[WIDTH-1];
            carry_q  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          aSh_q   <= aSh_q >> DIGIT;
          nbSh_q  <= nbSh_q >> DIGIT;
          carry_q <= digit_d[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          res_q   <= res_d;
          // Sign bit of the widened result comes from the saved operand signs and the final carry.
          if (cnt_q == LAST) begin
            diff_q     <= {top_d, res_d};
`ifdef SUB_TC_OVF_EN
            ovf_q      <= top_d ^ res_d[WIDTH-1];
`endif
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = outValid_q;
  assign diff      = diff_q;
`ifdef SUB_TC_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_sub_tc_16_16_seq.sv
// Self-checking bench for sub_tc_16_16_seq against an integer-arithmetic reference model.
// Checks the ovf output as well when SUB_TC_OVF_EN is defined.
module tb_sub_tc_16_16_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] diff;
`ifdef SUB_TC_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;

  sub_tc_16_16_seq #(.WIDTH(16), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
`ifdef SUB_TC_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] modelDiff(input logic [15:0] opA, input logic [15:0] opB);
    int d;
    d = int'($signed(opA)) - int'($signed(opB));
    return d[16:0];
  endfunction

  function automatic logic modelOvf(input logic [15:0] opA, input logic [15:0] opB);
    int d;
    d = int'($signed(opA)) - int'($signed(opB));
    return (d > 32767) || (d < -32768);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair, wait for acceptance, then scramble the inputs.
  task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    checkVal("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a        = opA;
    b        = opB;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] opA, input logic [15:0] opB,
                             input int holdCycles);
    int lat;
    waitResult(lat);
    checkVal({tag, "_latency"}, lat, 32'd4);
    checkVal({tag, "_diff"}, {15'd0, diff}, {15'd0, modelDiff(opA, opB)});
`ifdef SUB_TC_OVF_EN
    checkVal({tag, "_ovf"}, {31'd0, ovf}, {31'd0, modelOvf(opA, opB)});
`endif
    for (int i = 0; i < holdCycles; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkVal({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    checkVal({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] dirA [5];
    logic [15:0] dirB [5];
    logic [15:0] bpA, bpB, nA, nB;
    logic [16:0] held;
    logic        sawValid;
    logic [15:0] bbA [4];
    logic [15:0] bbB [4];
    logic [16:0] expQ [$];
    int k, results, extra, lastAccept, cyc, lat;
    logic acc, hs;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    tick();
    tick();
    checkVal("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("reset_diff", {15'd0, diff}, 32'd0);
`ifdef SUB_TC_OVF_EN
    checkVal("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    checkVal("idle_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Directed vectors including the signed extremes.
    dirA = '{16'h6080, 16'h8001, 16'h0005, 16'h7FFF, 16'h8000};
    dirB = '{16'h8001, 16'h8001, 16'h0007, 16'h8000, 16'h7FFF};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(dirA[i], dirB[i]);
      checkOutput("directed", dirA[i], dirB[i], 0);
    end

    // Back-pressure with ignored operands offered during DONE.
    bpA = 16'($urandom);
    bpB = 16'($urandom);
    nA  = 16'($urandom);
    nB  = 16'($urandom);
    applyStimulus(bpA, bpB);
    waitResult(lat);
    checkVal("bp_latency", lat, 32'd4);
    held     = diff;
    checkVal("bp_diff", {15'd0, held}, {15'd0, modelDiff(bpA, bpB)});
    a        = nA;
    b        = nB;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkVal("bp_hold_diff", {15'd0, diff}, {15'd0, modelDiff(bpA, bpB)});
      checkVal("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      checkVal("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkVal("bp_release_valid", {31'd0, out_valid}, 32'd0);
    checkVal("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("bp_retain_diff", {15'd0, diff}, {15'd0, modelDiff(bpA, bpB)});
    tick();
    in_valid = 1'b0;
    checkVal("bp_new_accept", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_new", nA, nB, 0);

    // Reset two cycles into a calculation drops it.
    applyStimulus(16'h1234, 16'h0042);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkVal("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sawValid = sawValid | out_valid;
    end
    checkVal("midrst_no_result", {31'd0, sawValid}, 32'd0);
    applyStimulus(16'h0003, 16'h0001);
    checkOutput("midrst_next", 16'h0003, 16'h0001, 0);

    // Random operands with random output stalls.
    for (int i = 0; i < 12; i++) begin
      nA = 16'($urandom);
      nB = 16'($urandom);
      applyStimulus(nA, nB);
      checkOutput("random", nA, nB, int'($urandom_range(0, 3)));
    end

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) begin
      bbA[i] = 16'($urandom);
      bbB[i] = 16'($urandom);
    end
    k          = 0;
    results    = 0;
    extra      = 0;
    lastAccept = -1;
    cyc        = 0;
    a          = bbA[0];
    b          = bbB[0];
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    while (results < 4 && cyc < 100) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        if (expQ.size() > 0) checkVal("b2b_diff", {15'd0, diff}, {15'd0, expQ.pop_front()});
        else extra++;
        results++;
      end
      if (acc) expQ.push_back(modelDiff(a, b));
      tick();
      cyc++;
      if (acc) begin
        if (lastAccept >= 0) checkVal("b2b_spacing", cyc - lastAccept, 32'd6);
        lastAccept = cyc;
        k++;
        if (k < 4) begin
          a = bbA[k];
          b = bbB[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    checkVal("b2b_results", results, 32'd4);
    checkVal("b2b_accepts", k, 32'd4);
    checkVal("b2b_extra", extra, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
